// File: rtl/addbit.sv
// -----------------------------------------------------------------------------
// addbit -- single-bit full adder with optional registered result capture and a
// saturating count of captured carry-out events.
//
// Ports
//   clk, rst_n       : clock (rising edge) and asynchronous active-low reset
//   a, b, ci         : addend bits and carry-in
//   sum, co          : combinational sum / carry-out (valid at all times,
//                      including during reset)
//   gen, prop        : combinational carry-generate (a&b) / propagate (a^b)
//   en               : capture enable for the registered outputs
//   clr              : synchronous clear of registered outputs and counter;
//                      wins over en
//   sum_q, co_q      : registered sum / carry-out
//   valid_q          : high once sum_q/co_q hold a captured result
//   co_cnt           : saturating count of captures that had co=1
//   co_cnt_sat       : high when co_cnt is all-ones
//
// Parameters
//   CNT_W            : width of co_cnt
//   REG_EN_DEFAULT   : reset value of the internal capture-arm flag. With the
//                      default of 1 capture is available on the first edge out
//                      of reset; with 0 the first edge after reset only arms
//                      the capture path.
// -----------------------------------------------------------------------------
module addbit #(
    parameter int CNT_W          = 8,
    parameter bit REG_EN_DEFAULT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             ci,
    output logic             sum,
    output logic             co,
    output logic             gen,
    output logic             prop,
    input  logic             en,
    input  logic             clr,
    output logic             sum_q,
    output logic             co_q,
    output logic             valid_q,
    output logic [CNT_W-1:0] co_cnt,
    output logic             co_cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             sum_q_q,   sum_q_d;
    logic             co_q_q,    co_q_d;
    logic             valid_q_q, valid_q_d;
    logic [CNT_W-1:0] co_cnt_q,  co_cnt_d;
    logic             reg_en_q,  reg_en_d;
    logic             capture;

    // Adder datapath: carry expressed through generate/propagate so the same
    // terms serve both co and the exported gen/prop.
    always_comb begin
        gen  = a & b;
        prop = a ^ b;
        sum  = prop ^ ci;
        co   = gen | (prop & ci);
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        sum_q_d   = sum_q_q;
        co_q_d    = co_q_q;
        valid_q_d = valid_q_q;
        co_cnt_d  = co_cnt_q;
        reg_en_d  = 1'b1;
        capture   = en & reg_en_q;

        if (clr) begin
            sum_q_d   = 1'b0;
            co_q_d    = 1'b0;
            valid_q_d = 1'b0;
            co_cnt_d  = '0;
        end else if (capture) begin
            sum_q_d   = sum;
            co_q_d    = co;
            valid_q_d = 1'b1;
            // Saturate rather than wrap so a full counter stays meaningful.
            if (co && (co_cnt_q != CNT_MAX)) begin
                co_cnt_d = co_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: every state flop sits on the async reset so the registered
    // outputs clear immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q_q   <= 1'b0;
            co_q_q    <= 1'b0;
            valid_q_q <= 1'b0;
            co_cnt_q  <= '0;
            reg_en_q  <= REG_EN_DEFAULT;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the
            // pre-edge values, independent of statement order.
            sum_q_q   <= sum_q_d;
            co_q_q    <= co_q_d;
            valid_q_q <= valid_q_d;
            co_cnt_q  <= co_cnt_d;
            reg_en_q  <= reg_en_d;
        end
    end

    always_comb begin
        sum_q      = sum_q_q;
        co_q       = co_q_q;
        valid_q    = valid_q_q;
        co_cnt     = co_cnt_q;
        co_cnt_sat = &co_cnt_q;
    end

endmodule

// File: tb/tb_addbit.sv
// -----------------------------------------------------------------------------
// tb_addbit -- self-checking bench for addbit: exhaustive combinational sweep,
// 4-bit ripple chain, registered capture/hold/clear, reset behaviour,
// counter saturation on a narrow instance, and randomized cycles checked
// against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_addbit;

    logic clk;
    logic rst_n;

    // Main instance (CNT_W = 8)
    logic       a, b, ci, en, clr;
    logic       sum, co, gen, prop, sum_q, co_q, valid_q, co_cnt_sat;
    logic [7:0] co_cnt;

    // Narrow instance (CNT_W = 2) for saturation
    logic       a2, b2, ci2, en2, clr2;
    logic       sum2, co2, gen2, prop2, sum_q2, co_q2, valid_q2, co_cnt_sat2;
    logic [1:0] co_cnt2;

    // Four-bit ripple chain
    logic [3:0] r1, r2;
    logic       cin;
    logic [4:0] carry;
    logic [3:0] chain_sum, chain_gen, chain_prop, chain_sq, chain_cq, chain_vq, chain_sat;
    logic [7:0] chain_cnt [4];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state for the main instance
    int m_sum_q, m_co_q, m_valid_q, m_cnt;

    addbit #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .ci(ci),
        .sum(sum), .co(co), .gen(gen), .prop(prop),
        .en(en), .clr(clr), .sum_q(sum_q), .co_q(co_q), .valid_q(valid_q),
        .co_cnt(co_cnt), .co_cnt_sat(co_cnt_sat)
    );

    addbit #(.CNT_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .ci(ci2),
        .sum(sum2), .co(co2), .gen(gen2), .prop(prop2),
        .en(en2), .clr(clr2), .sum_q(sum_q2), .co_q(co_q2), .valid_q(valid_q2),
        .co_cnt(co_cnt2), .co_cnt_sat(co_cnt_sat2)
    );

    assign carry[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_chain
        addbit #(.CNT_W(8)) u_bit (
            .clk(clk), .rst_n(rst_n), .a(r1[i]), .b(r2[i]), .ci(carry[i]),
            .sum(chain_sum[i]), .co(carry[i+1]), .gen(chain_gen[i]), .prop(chain_prop[i]),
            .en(1'b0), .clr(1'b0), .sum_q(chain_sq[i]), .co_q(chain_cq[i]),
            .valid_q(chain_vq[i]), .co_cnt(chain_cnt[i]), .co_cnt_sat(chain_sat[i])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Combinational reference: {co,sum} is the arithmetic sum of three bits.
    task automatic check_comb(input string tag);
        int t;
        t = int'(a) + int'(b) + int'(ci);
        check({tag, ".sum"},  int'(sum),  t % 2);
        check({tag, ".co"},   int'(co),   t / 2);
        check({tag, ".gen"},  int'(gen),  (a && b) ? 1 : 0);
        check({tag, ".prop"}, int'(prop), (int'(a) + int'(b)) % 2);
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".sum_q"},   int'(sum_q),      m_sum_q);
        check({tag, ".co_q"},    int'(co_q),       m_co_q);
        check({tag, ".valid_q"}, int'(valid_q),    m_valid_q);
        check({tag, ".co_cnt"},  int'(co_cnt),     m_cnt);
        check({tag, ".sat"},     int'(co_cnt_sat), (m_cnt == 255) ? 1 : 0);
    endtask

    // Advance the model with the inputs present before the edge, take the
    // edge, then compare away from it.
    task automatic step(input string tag);
        int t;
        t = int'(a) + int'(b) + int'(ci);
        if (clr) begin
            m_sum_q = 0; m_co_q = 0; m_valid_q = 0; m_cnt = 0;
        end else if (en) begin
            m_sum_q   = t % 2;
            m_co_q    = t / 2;
            m_valid_q = 1;
            if (t / 2 == 1 && m_cnt < 255) m_cnt = m_cnt + 1;
        end
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    task automatic model_reset();
        m_sum_q = 0; m_co_q = 0; m_valid_q = 0; m_cnt = 0;
    endtask

    initial begin
        int sel;
        logic [3:0] bits;
        rst_n = 1'b0;
        {a, b, ci, en, clr}      = '0;
        {a2, b2, ci2, en2, clr2} = '0;
        r1 = '0; r2 = '0; cin = 1'b0;
        model_reset();

        // Reset values, before any clock edge
        #2;
        check_regs("reset");

        // Exhaustive combinational sweep while still in reset
        for (int i = 0; i < 8; i++) begin
            {a, b, ci} = 3'(i);
            #1;
            check_comb($sformatf("sweep%0d", i));
        end
        check_regs("reset_hold");

        // Leave reset between edges
        @(negedge clk);
        rst_n = 1'b1;
        {a, b, ci} = 3'b000;

        // Four-bit ripple chain
        r1 = 4'hA; r2 = 4'h2; cin = 1'b1;
        #1;
        bits = chain_sum;
        check("chain_bits", int'(bits), 4'b1101);
        check("chain_res",  int'(carry[4]) * 16 + int'(chain_sum), 16'h0D);
        r1 = 4'hA; r2 = 4'h0; cin = 1'b0;
        #1;
        check("chain_res2", int'(carry[4]) * 16 + int'(chain_sum), 16'h0A);
        for (int i = 0; i < 8; i++) begin
            r1 = 4'($urandom); r2 = 4'($urandom); cin = 1'($urandom);
            #1;
            check("chain_rnd", int'(carry[4]) * 16 + int'(chain_sum),
                  int'(r1) + int'(r2) + int'(cin));
        end

        // Single capture, then hold with en=0
        @(negedge clk);
        a = 1; b = 1; ci = 0; en = 1;
        step("cap1");
        check("cap1.cnt_lit", int'(co_cnt), 1);
        a = 0; b = 1; ci = 0; en = 0;
        step("hold");
        check("hold.sum_q_lit", int'(sum_q), 0);
        check("hold.co_q_lit",  int'(co_q),  1);

        // Randomized cycles; mid-cycle input changes must not touch registers
        for (int i = 0; i < 60; i++) begin
            {a, b, ci} = 3'($urandom);
            en  = 1'($urandom_range(0, 3) != 0);
            clr = 1'($urandom_range(0, 9) == 0);
            #2;
            check_comb("rnd");
            {a, b, ci} = 3'($urandom);
            #1;
            check_comb("rnd2");
            step("rnd");
        end

        // clr and en together: clear wins
        a = 1; b = 1; ci = 1; en = 1; clr = 1;
        step("clr_en");
        check("clr_en.valid_lit", int'(valid_q), 0);
        clr = 0;

        // Bring count to 2, then reset asynchronously between edges
        a = 1; b = 1; ci = 0; en = 1;
        step("pre_rst1");
        step("pre_rst2");
        check("pre_rst.cnt_lit", int'(co_cnt), 2);
        en = 0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_regs("async_rst");
        {a, b, ci} = 3'b011;
        #1;
        check_comb("rst_comb");
        @(posedge clk);
        #1;
        check_regs("rst_held");

        // Saturation on the narrow instance
        @(negedge clk);
        rst_n = 1'b1;
        a2 = 1; b2 = 1; ci2 = 0; en2 = 1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            sel = (i < 3) ? i : 3;
            check($sformatf("w2.cnt%0d", i), int'(co_cnt2), sel);
            check($sformatf("w2.sat%0d", i), int'(co_cnt_sat2), (i >= 3) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
